// File: rtl/instr_inv_queue.sv
// Instruction-side invalidation queue: buffers committed store line addresses, coalesces duplicates,
// broadcasts the head to every consumer and collapses into a flush-all request on overflow.
module instr_inv_queue #(
  parameter int DEPTH         = 4,
  parameter int ADDR_W        = 32,
  parameter int LINE_W        = 4,
  parameter int NUM_CONSUMERS = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 inv_valid,
  input  logic [ADDR_W-1:0]                    inv_addr,
  output logic [NUM_CONSUMERS-1:0]             req_valid,
  output logic [ADDR_W-3-$clog2(LINE_W):0]     req_line,
  output logic                                 req_flush_all,
  input  logic [NUM_CONSUMERS-1:0]             ack,
  output logic                                 empty,
  output logic [$clog2(DEPTH):0]               occupancy,
  output logic [15:0]                          flush_events
);
  localparam int OFS  = 2 + $clog2(LINE_W);
  localparam int LA_W = ADDR_W - OFS;
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam logic [NUM_CONSUMERS-1:0] ALL_DONE = '1;

  typedef enum logic {NORMAL = 1'b0, FLUSH = 1'b1} state_t;

  state_t                   state;
  logic [PW-1:0]            head;
  logic [PW-1:0]            tail;
  logic [CW-1:0]            count;
  logic [NUM_CONSUMERS-1:0] done;
  logic                     reflush;
  logic [LA_W-1:0]          lines [DEPTH];

  logic [LA_W-1:0]          push_line;
  logic                     presenting;
  logic                     hit;
  logic                     push;
  logic                     full;
  logic                     retire;
  logic                     overflow;
  logic                     reflush_eff;
  logic [NUM_CONSUMERS-1:0] acc;
  logic [NUM_CONSUMERS-1:0] done_all;
  logic                     unused_addr_bits;

  // Distance of a slot from the head, wrapping modulo DEPTH.
  function automatic logic [PW-1:0] slot_ofs(input int idx, input logic [PW-1:0] h);
    return PW'(idx) - h;
  endfunction

  assign push_line        = inv_addr[ADDR_W-1:OFS];
  assign unused_addr_bits = ^inv_addr[OFS-1:0];

  assign presenting  = (count != '0) || (state == FLUSH);
  assign acc         = ack & req_valid;
  assign done_all    = done | acc;
  assign retire      = presenting && (done_all == ALL_DONE);
  assign full        = (count == CW'(DEPTH));
  assign reflush_eff = reflush || (inv_valid && (done != '0));

  // A head already seen by some consumer may have been invalidated before this store, so it cannot absorb it.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (({1'b0, slot_ofs(i, head)} < count) && (lines[i] == push_line) &&
          !((PW'(i) == head) && (done != '0)))
        hit = 1'b1;
    end
  end

  assign push     = inv_valid && !hit && (state == NORMAL);
  assign overflow = push && full && !retire;

  assign req_valid     = presenting ? ~done : '0;
  assign req_flush_all = (state == FLUSH);
  assign req_line      = ((state == NORMAL) && (count != '0)) ? lines[head] : '0;
  assign empty         = (state == NORMAL) && (count == '0);
  assign occupancy     = count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= NORMAL;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      done         <= '0;
      reflush      <= 1'b0;
      flush_events <= '0;
    end else if (state == NORMAL) begin
      if (overflow) begin
        state <= FLUSH;
        head  <= '0;
        tail  <= '0;
        count <= '0;
        done  <= '0;
        if (flush_events != 16'hFFFF)
          flush_events <= flush_events + 16'd1;
      end else begin
        if (push)
          tail <= tail + 1'b1;
        if (retire) begin
          head <= head + 1'b1;
          done <= '0;
        end else begin
          done <= done_all;
        end
        count <= count + CW'(push) - CW'(retire);
      end
    end else begin
      // A store that arrived after some consumer already flushed needs one more flush round.
      if (retire) begin
        done    <= '0;
        reflush <= 1'b0;
        if (!reflush_eff)
          state <= NORMAL;
      end else begin
        done    <= done_all;
        reflush <= reflush_eff;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !overflow)
      lines[tail] <= push_line;
  end

endmodule

// File: tb/tb_instr_inv_queue.sv
// Bench for instr_inv_queue: queue-level reference model compared every cycle plus directed literal checks,
// with a second 3-consumer, 8-deep instance exercised directly.
module tb_instr_inv_queue;
  localparam int LA_W = 28;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inv_valid = 1'b0;
  logic [31:0] inv_addr = '0;
  logic [1:0]  ack = '0;
  logic [1:0]  req_valid;
  logic [LA_W-1:0] req_line;
  logic        req_flush_all;
  logic        empty;
  logic [2:0]  occupancy;
  logic [15:0] flush_events;

  logic        b_inv_valid = 1'b0;
  logic [31:0] b_inv_addr = '0;
  logic [2:0]  b_ack = '0;
  logic [2:0]  b_req_valid;
  logic [LA_W-1:0] b_req_line;
  logic        b_flush_all;
  logic        b_empty;
  logic [3:0]  b_occ;
  logic [15:0] b_fe;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_inv_queue dut (
    .clk(clk), .rst(rst), .inv_valid(inv_valid), .inv_addr(inv_addr),
    .req_valid(req_valid), .req_line(req_line), .req_flush_all(req_flush_all),
    .ack(ack), .empty(empty), .occupancy(occupancy), .flush_events(flush_events)
  );

  instr_inv_queue #(.DEPTH(8), .ADDR_W(32), .LINE_W(4), .NUM_CONSUMERS(3)) dut3 (
    .clk(clk), .rst(rst), .inv_valid(b_inv_valid), .inv_addr(b_inv_addr),
    .req_valid(b_req_valid), .req_line(b_req_line), .req_flush_all(b_flush_all),
    .ack(b_ack), .empty(b_empty), .occupancy(b_occ), .flush_events(b_fe)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of pending lines, per-consumer done bits, and a flush flag.
  logic [LA_W-1:0] mq[$];
  logic [1:0]      mdone = '0;
  bit              mflush = 1'b0;
  bit              mrefl = 1'b0;
  int              mfe = 0;

  function automatic logic [1:0] m_pres();
    return (mq.size() != 0 || mflush) ? ~mdone : 2'b00;
  endfunction

  task automatic model_step();
    logic [1:0] pres, acc;
    bit ret, hit;
    logic [LA_W-1:0] ln;
    pres = m_pres();
    acc  = ack & pres;
    ret  = (pres != 2'b00) && ((mdone | acc) == 2'b11);
    if (!mflush) begin
      ln  = inv_addr[31:4];
      hit = 1'b0;
      foreach (mq[k])
        if (mq[k] == ln && !(k == 0 && mdone != 2'b00)) hit = 1'b1;
      if (inv_valid && !hit && mq.size() == 4 && !ret) begin
        mq.delete();
        mdone  = 2'b00;
        mflush = 1'b1;
        if (mfe < 65535) mfe++;
      end else begin
        if (ret) begin
          void'(mq.pop_front());
          mdone = 2'b00;
        end else begin
          mdone = mdone | acc;
        end
        if (inv_valid && !hit) mq.push_back(ln);
      end
    end else begin
      if (inv_valid && mdone != 2'b00) mrefl = 1'b1;
      if (ret) begin
        mdone = 2'b00;
        if (!mrefl) mflush = 1'b0;
        mrefl = 1'b0;
      end else begin
        mdone = mdone | acc;
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      mdone  = 2'b00;
      mflush = 1'b0;
      mrefl  = 1'b0;
      mfe    = 0;
    end else begin
      model_step();
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("cmp_req_valid", req_valid, m_pres());
      chk("cmp_flush_all", req_flush_all, mflush);
      chk("cmp_req_line", req_line, (mflush || mq.size() == 0) ? '0 : mq[0]);
      chk("cmp_empty", empty, (!mflush && mq.size() == 0));
      chk("cmp_occupancy", occupancy, mq.size());
      chk("cmp_flush_events", flush_events, mfe);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic v, input logic [31:0] a, input logic [1:0] k);
    inv_valid = v;
    inv_addr  = a;
    ack       = k;
    cyc();
    inv_valid = 1'b0;
    inv_addr  = '0;
    ack       = 2'b00;
  endtask

  task automatic drain();
    int n;
    n   = 0;
    ack = 2'b11;
    while (!empty && n < 20) begin
      cyc();
      n++;
    end
    ack = 2'b00;
    chk("drain_empty", empty, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_valid", req_valid, 2'b00);
    chk("rst_empty", empty, 1'b1);
    chk("rst_occupancy", occupancy, 3'd0);
    chk("rst_flush_events", flush_events, 16'd0);
    chk("rst_req_line", req_line, '0);
    chk("rst_flush_all", req_flush_all, 1'b0);
    rst = 1'b0;
    cyc();

    // Single push and split acknowledge
    step(1'b1, 32'h8000_1234, 2'b00);
    chk("single_req_valid", req_valid, 2'b11);
    chk("single_req_line", req_line, 28'h800_0123);
    step(1'b0, 32'h0, 2'b01);
    chk("single_ack0", req_valid, 2'b10);
    step(1'b0, 32'h0, 2'b10);
    chk("single_ack1", req_valid, 2'b00);
    chk("single_empty", empty, 1'b1);

    // Coalescing
    step(1'b1, 32'h8000_1230, 2'b00);
    step(1'b1, 32'h8000_123C, 2'b00);
    step(1'b1, 32'h8000_1240, 2'b00);
    chk("coal_occ", occupancy, 3'd2);
    chk("coal_head", req_line, 28'h800_0123);
    step(1'b0, 32'h0, 2'b01);
    step(1'b1, 32'h8000_1234, 2'b00);
    chk("coal_readd_occ", occupancy, 3'd3);
    chk("model_size_pin", mq.size(), 3);
    chk("model_tail_pin", mq[2], 28'h800_0123);
    drain();

    // Full with simultaneous retire
    for (int i = 0; i < 4; i++) step(1'b1, 32'h1000 + 32'(i) * 32'h10, 2'b00);
    chk("full_occ", occupancy, 3'd4);
    step(1'b1, 32'h1040, 2'b11);
    chk("full_retire_occ", occupancy, 3'd4);
    chk("full_retire_noflush", req_flush_all, 1'b0);
    chk("full_retire_fe", flush_events, 16'd0);
    chk("full_retire_head", req_line, 28'h101);
    drain();

    // Overflow into flush, drop and reflush
    for (int i = 0; i < 4; i++) step(1'b1, 32'h2000 + 32'(i) * 32'h10, 2'b00);
    step(1'b1, 32'h2040, 2'b00);
    chk("ovf_flush_all", req_flush_all, 1'b1);
    chk("ovf_req_valid", req_valid, 2'b11);
    chk("ovf_occ", occupancy, 3'd0);
    chk("ovf_fe", flush_events, 16'd1);
    chk("ovf_line", req_line, '0);
    chk("model_fe_pin", mfe, 1);
    step(1'b1, 32'h3000, 2'b00);
    chk("flush_drop_valid", req_valid, 2'b11);
    step(1'b0, 32'h0, 2'b01);
    chk("flush_ack0", req_valid, 2'b10);
    step(1'b1, 32'h3000, 2'b00);
    step(1'b0, 32'h0, 2'b10);
    chk("reflush_valid", req_valid, 2'b11);
    chk("reflush_flag", req_flush_all, 1'b1);
    step(1'b0, 32'h0, 2'b11);
    chk("reflush_done_empty", empty, 1'b1);
    chk("reflush_done_flag", req_flush_all, 1'b0);
    chk("reflush_fe", flush_events, 16'd1);

    // Spurious acknowledge while empty
    step(1'b0, 32'h0, 2'b11);
    chk("spur_empty", empty, 1'b1);
    chk("spur_valid", req_valid, 2'b00);

    // Three-consumer, eight-deep instance
    b_inv_valid = 1'b1;
    b_inv_addr  = 32'h4000;
    cyc();
    b_inv_valid = 1'b0;
    chk("b_valid", b_req_valid, 3'b111);
    chk("b_occ", b_occ, 4'd1);
    chk("b_line", b_req_line, 28'h400);
    b_ack = 3'b100;
    cyc();
    chk("b_ack_hi", b_req_valid, 3'b011);
    chk("b_occ_hold", b_occ, 4'd1);
    b_ack = 3'b011;
    cyc();
    b_ack = 3'b000;
    chk("b_retire_occ", b_occ, 4'd0);
    chk("b_retire_empty", b_empty, 1'b1);
    chk("b_retire_valid", b_req_valid, 3'b000);
    chk("b_flush_all", b_flush_all, 1'b0);
    chk("b_fe", b_fe, 16'd0);

    // Asynchronous reset mid-acknowledge
    step(1'b1, 32'h5000, 2'b00);
    step(1'b1, 32'h5010, 2'b00);
    step(1'b1, 32'h5020, 2'b00);
    chk("pre_rst_occ", occupancy, 3'd3);
    step(1'b0, 32'h0, 2'b01);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", req_valid, 2'b00);
    chk("arst_occ", occupancy, 3'd0);
    chk("arst_empty", empty, 1'b1);
    chk("arst_line", req_line, '0);
    chk("arst_flush_all", req_flush_all, 1'b0);
    cyc();
    rst = 1'b0;
    cyc();
    step(1'b1, 32'h6000, 2'b00);
    chk("post_rst_valid", req_valid, 2'b11);
    chk("post_rst_line", req_line, 28'h600);
    chk("post_rst_occ", occupancy, 3'd1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
